ssd_scan_mux: RTL and testbench
===============================

// Module: ssd_scan_mux
// PURPOSE
//  Parametrised, time-multiplexed driver for a common-anode 7-segment display with N digits.
//  Supports any digit count, a refresh prescaler, per-digit decimal point and blanking,
//  tear-free frame-synchronous updates and anti-ghosting dead time.
//  Sits between the datapath (hex nibbles) and the board anode/cathode pins.
// PARAMETERS
//  N_DIGITS     4       number of digits scanned; must be >= 1
//  REFRESH_DIV  100000  clk cycles per digit slot; must be >= 2
//  DEAD_CYCLES  2       cycles at slot start with all anodes off; must be < REFRESH_DIV
// PORTS
//  clk          in   1            system clock, rising edge
//  rst_n        in   1            synchronous reset, active-low
//  digits_in    in   4*N_DIGITS   hex nibbles; digit k = digits_in[4k+3:4k], digit 0 rightmost
//  dp_in        in   N_DIGITS     decimal point request per digit, 1 = lit
//  blank_in     in   N_DIGITS     1 = digit dark
//  load         in   1            capture digits_in/dp_in/blank_in into staging
//  frame_start  out  1            1-cycle pulse when the scan wraps to digit 0
//  anode        out  N_DIGITS     active-low digit enables; at most one bit low
//  cathode      out  8            active-low {a,b,c,d,e,f,g,dp}; cathode[0] = dp
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - prescaler=0, index=0, pending=0, frame_start=0, anode=all 1, cathode=8'hFF
//   - shadow: digits=0, dp=0, blank=all 1; display stays dark until the first load commits
//  Prescaler counts 0..REFRESH_DIV-1, then wraps.
//   - tick = (count==REFRESH_DIV-1); on tick, index advances and wraps N_DIGITS-1 -> 0
//   - boundary = tick && index==N_DIGITS-1; frame_start registered, high the cycle after boundary
//  Load handshake (staging -> shadow):
//   - load=1, no boundary: staging <= inputs, pending <= 1; repeated loads overwrite staging
//   - boundary with pending=1: shadow <= staging, pending <= 0
//   - load and boundary in the same cycle: shadow <= current inputs (bypass), pending <= 0
//   - shadow never changes mid-frame
//  Slot output (registered; 1 cycle after count/index):
//   - count < DEAD_CYCLES: anode=all 1, cathode=8'hFF
//   - else if shadow blank[index]: anode=all 1, cathode=8'hFF
//   - else: anode=~(1<<index), cathode={seg(nibble[index]), ~dp[index]}
//  seg() active-low a..g, MSB=a:
//   0=0000001  1=1001111  2=0010010  3=0000110  4=1001100  5=0100100  6=0100000
//   7=0001111  8=0000000  9=0000100  A=0001000  B=1100000  C=0110001  D=1000010
//   E=0110000  F=0111000
//  Widths/edge cases:
//   - index width = max(1, clog2(N_DIGITS)); N_DIGITS=1: index stays 0, boundary every tick
//   - reset mid-frame: aborts the slot and discards staging/pending the next cycle
// CONFIGURATION
//  SSD_LZB_EN defined (leading-zero blanking):
//   - a digit is blanked when its shadow nibble and all higher-index nibbles are 0
//   - digit 0 is never blanked by this rule
//   - dp_in=1 on a blanked zero keeps the anode on and shows dp only (cathode=8'hFE)
//  SSD_LZB_EN undefined: zeros display normally; only blank_in blanks digits.
// TESTING (N_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2 unless stated)
//  1. rst_n=0 for 3 clk, release, no load -> anode=4'hF, cathode=8'hFF for >= 2 full frames
//  2. load digits_in=16'h1A2F, dp=0, blank=0 mid-frame -> unchanged until the next frame_start;
//     then slot0 anode=1110 cathode=01110001, slot3 anode=0111 cathode=10011111;
//     dead cycles 0-1 of each slot = all off
//  3. two loads in one frame (16'h1111 then 16'h2222) -> next frame shows only 2222;
//     load on the boundary cycle with 16'h3333 -> 3333 commits on that boundary
//  4. blank_in=4'b0100, dp_in=4'b0001 -> digit2 slot all dark; digit0 cathode[0]=0
//  5. SSD_LZB_EN, digits_in=16'h0050 -> digits 3,2 dark, digit1 shows 5, digit0 shows 0;
//     16'h0000 -> only digit0 lit with "0"; without the macro all four digits are lit
//  6. N_DIGITS=1, REFRESH_DIV=2, DEAD_CYCLES=1 -> frame_start every 2 cycles;
//     rst_n low mid-slot -> outputs dark the next cycle

Source files
------------

// File: rtl/ssd_scan_mux_if.sv
// Bus bundle between a datapath and ssd_scan_mux: display payload and load strobe in,
// frame-start pulse and active-low anode/cathode pins out.
interface ssd_scan_mux_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic                  load;
  logic                  frame_start;
  logic [N_DIGITS-1:0]   anode;
  logic [7:0]            cathode;

  modport master (
    output digits_in, dp_in, blank_in, load,
    input  frame_start, anode, cathode
  );

  modport slave (
    input  digits_in, dp_in, blank_in, load,
    output frame_start, anode, cathode
  );
endinterface

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous staging,
// dead-time anti-ghosting and per-digit dp/blank. Define SSD_LZB_EN for leading-zero blanking.
module ssd_scan_mux #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ssd_scan_mux_if.slave   bus
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned DW    = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [DW-1:0]       stg_dig_q, stg_dig_d;
  logic [N_DIGITS-1:0] stg_dp_q, stg_dp_d;
  logic [N_DIGITS-1:0] stg_blank_q, stg_blank_d;
  logic [DW-1:0]       sh_dig_q, sh_dig_d;
  logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [N_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic                frame_start_q, frame_start_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;

  logic                tick_c;
  logic                boundary_c;
  logic [N_DIGITS-1:0] lzb_c;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick_c     = (cnt_q == CNT_LAST);
  assign boundary_c = tick_c && (idx_q == IDX_LAST);

  // Scan timing plus staging -> shadow handoff, which only ever happens on a frame boundary.
  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    pending_d     = pending_q;
    stg_dig_d     = stg_dig_q;
    stg_dp_d      = stg_dp_q;
    stg_blank_d   = stg_blank_q;
    sh_dig_d      = sh_dig_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    frame_start_d = boundary_c;

    if (tick_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (boundary_c && bus.load) begin
      sh_dig_d   = bus.digits_in;
      sh_dp_d    = bus.dp_in;
      sh_blank_d = bus.blank_in;
      pending_d  = 1'b0;
    end else if (boundary_c && pending_q) begin
      sh_dig_d   = stg_dig_q;
      sh_dp_d    = stg_dp_q;
      sh_blank_d = stg_blank_q;
      pending_d  = 1'b0;
    end else if (bus.load) begin
      stg_dig_d   = bus.digits_in;
      stg_dp_d    = bus.dp_in;
      stg_blank_d = bus.blank_in;
      pending_d   = 1'b1;
    end
  end

`ifdef SSD_LZB_EN
  // A digit is a leading zero when it and every higher digit are zero; digit 0 is exempt.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lzb_c    = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (sh_dig_q[4*k +: 4] == 4'h0);
      lzb_c[k] = zero_run;
    end
  end
`else
  assign lzb_c = '0;
`endif

  // Pin image for the current slot: dead time first, then blanking, then the glyph.
  always_comb begin
    logic [3:0] nib;
    logic       dp_sel;
    logic       blk_sel;
    logic       lzb_sel;
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blk_sel   = 1'b1;
    lzb_sel   = 1'b0;
    anode_d   = '1;
    cathode_d = 8'hFF;

    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib     = sh_dig_q[4*k +: 4];
        dp_sel  = sh_dp_q[k];
        blk_sel = sh_blank_q[k];
        lzb_sel = lzb_c[k];
      end
    end

    if ((cnt_q >= CNT_DEAD) && !blk_sel) begin
      if (lzb_sel) begin
        if (dp_sel) begin
          anode_d   = ~(N_DIGITS'(1) << idx_q);
          cathode_d = 8'hFE;
        end
      end else begin
        anode_d   = ~(N_DIGITS'(1) << idx_q);
        cathode_d = {seg7(nib), ~dp_sel};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      stg_dig_q     <= '0;
      stg_dp_q      <= '0;
      stg_blank_q   <= '1;
      sh_dig_q      <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '1;
      frame_start_q <= 1'b0;
      anode_q       <= '1;
      cathode_q     <= 8'hFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      stg_dig_q     <= stg_dig_d;
      stg_dp_q      <= stg_dp_d;
      stg_blank_q   <= stg_blank_d;
      sh_dig_q      <= sh_dig_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      frame_start_q <= frame_start_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
    end
  end

  assign bus.frame_start = frame_start_q;
  assign bus.anode       = anode_q;
  assign bus.cathode     = cathode_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed bench for ssd_scan_mux: a 4-digit scanner (REFRESH_DIV=8, DEAD_CYCLES=2)
// driven from a vector table, plus a 1-digit scanner (REFRESH_DIV=2, DEAD_CYCLES=1).
module tb_ssd_scan_mux;

  localparam int unsigned DC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rst1_n;

  always #5 clk = ~clk;

  ssd_scan_mux_if #(.N_DIGITS(4)) bus ();
  ssd_scan_mux_if #(.N_DIGITS(1)) bus1 ();

  ssd_scan_mux #(.N_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ssd_scan_mux #(.N_DIGITS(1), .REFRESH_DIV(2), .DEAD_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][7:0] cath;   // expected cathode per digit; 8'hFF means the slot stays dark
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] blank,
                              input logic [7:0] c3, input logic [7:0] c2,
                              input logic [7:0] c1, input logic [7:0] c0);
    vec_t v;
    v.dig   = dig;
    v.dp    = dp;
    v.blank = blank;
    v.cath  = {c3, c2, c1, c0};
    return v;
  endfunction

  task automatic chk_out(input string name, input logic [3:0] a_exp, input logic [7:0] c_exp);
    n_vec++;
    if (bus.anode !== a_exp || bus.cathode !== c_exp) begin
      n_err++;
      $display("FAIL %s @%0t: anode=%b cathode=%h, expected anode=%b cathode=%h",
               name, $time, bus.anode, bus.cathode, a_exp, c_exp);
    end
  endtask

  task automatic chk_fs(input string name, input logic fs_exp);
    n_vec++;
    if (bus.frame_start !== fs_exp) begin
      n_err++;
      $display("FAIL %s @%0t: frame_start=%b, expected %b", name, $time, bus.frame_start, fs_exp);
    end
  endtask

  task automatic chk1(input string name, input logic a_exp, input logic [7:0] c_exp, input logic fs_exp);
    n_vec++;
    if (bus1.anode !== a_exp || bus1.cathode !== c_exp || bus1.frame_start !== fs_exp) begin
      n_err++;
      $display("FAIL %s @%0t: anode=%b cathode=%h fs=%b, expected anode=%b cathode=%h fs=%b",
               name, $time, bus1.anode, bus1.cathode, bus1.frame_start, a_exp, c_exp, fs_exp);
    end
  endtask

  task automatic apply_load(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] blank);
    bus.digits_in = dig;
    bus.dp_in     = dp;
    bus.blank_in  = blank;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  // Returns on the negedge where frame_start is seen; optionally checks the display stays dark.
  task automatic wait_frame(input bit chk_dark);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (chk_dark) chk_out("pre_commit_dark", 4'hF, 8'hFF);
      if (bus.frame_start === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL frame_timeout @%0t: frame_start=0 for 100 cycles, expected a pulse", $time);
    end
  endtask

  // One full frame starting right after the frame_start sample.
  task automatic scan(input string name, input vec_t v);
    logic [3:0] a_exp;
    logic [7:0] c_exp;
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        a_exp = 4'hF;
        c_exp = 8'hFF;
        if (c >= DC && v.cath[j] != 8'hFF) begin
          a_exp = ~(4'(1) << j);
          c_exp = v.cath[j];
        end
        chk_out(name, a_exp, c_exp);
        if (c == 7) chk_fs({name, "_fs"}, (j == 3) ? 1'b1 : 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int pulses;

    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.load       = 1'b0;
    bus1.digits_in = '0;
    bus1.dp_in     = '0;
    bus1.blank_in  = '0;
    bus1.load      = 1'b0;
    rst_n          = 1'b0;
    rst1_n         = 1'b0;

    vecs[0] = mk(16'h1A2F, 4'b0000, 4'b0000, 8'h9F, 8'h11, 8'h25, 8'h71);
    vecs[1] = mk(16'h8421, 4'b0001, 4'b0100, 8'h01, 8'hFF, 8'h25, 8'h9E);
`ifdef SSD_LZB_EN
    vecs[2] = mk(16'h0050, 4'b0000, 4'b0000, 8'hFF, 8'hFF, 8'h49, 8'h03);
    vecs[3] = mk(16'h0000, 4'b0000, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'h03);
    vecs[4] = mk(16'h0007, 4'b0100, 4'b0000, 8'hFF, 8'hFE, 8'hFF, 8'h1F);
`else
    vecs[2] = mk(16'h0050, 4'b0000, 4'b0000, 8'h03, 8'h03, 8'h49, 8'h03);
    vecs[3] = mk(16'h0000, 4'b0000, 4'b0000, 8'h03, 8'h03, 8'h03, 8'h03);
    vecs[4] = mk(16'h0007, 4'b0100, 4'b0000, 8'h03, 8'h02, 8'h03, 8'h1F);
`endif
    vecs[5] = mk(16'h9BCD, 4'b1010, 4'b0000, 8'h08, 8'hC1, 8'h62, 8'h85);
    vecs[6] = mk(16'hE634, 4'b0000, 4'b0010, 8'h61, 8'h41, 8'hFF, 8'h99);
    vecs[7] = mk(16'h3000, 4'b0000, 4'b0000, 8'h0D, 8'h03, 8'h03, 8'h03);
    vecs[8] = mk(16'h5678, 4'b0000, 4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Reset state, then two dark frames with no load
    repeat (3) @(negedge clk);
    chk_out("reset_state", 4'hF, 8'hFF);
    chk_fs("reset_fs", 1'b0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk_out("idle_dark", 4'hF, 8'hFF);
      if (bus.frame_start === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL idle_frame_count: %0d frame_start pulses, expected 2", pulses);
    end
    repeat (3) @(negedge clk);

    // Table: load mid-frame, wait for commit, check the whole next frame
    for (int i = 0; i < NV; i++) begin
      apply_load(vecs[i].dig, vecs[i].dp, vecs[i].blank);
      wait_frame(i == 0);
      scan($sformatf("vec%0d", i), vecs[i]);
    end

    // Two loads in one frame: last one wins
    apply_load(16'h1111, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    apply_load(16'h2222, 4'h0, 4'h0);
    wait_frame(1'b0);
    scan("double_load", mk(16'h2222, 4'h0, 4'h0, 8'h25, 8'h25, 8'h25, 8'h25));

    // Pending 4444, then a load on the boundary cycle bypasses staging with 3333
    apply_load(16'h4444, 4'h0, 4'h0);
    repeat (30) @(negedge clk);
    bus.digits_in = 16'h3333;
    bus.dp_in     = 4'h0;
    bus.blank_in  = 4'h0;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
    chk_fs("boundary_load_fs", 1'b1);
    scan("boundary_load", mk(16'h3333, 4'h0, 4'h0, 8'h0D, 8'h0D, 8'h0D, 8'h0D));

    // Reset mid-slot with a load pending: dark next cycle, staging discarded
    repeat (4) @(negedge clk);
    chk_out("pre_reset_lit", 4'b1110, 8'h0D);
    apply_load(16'hAAAA, 4'h0, 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("reset_abort", 4'hF, 8'hFF);
    chk_fs("reset_abort_fs", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk_out("post_reset_dark", 4'hF, 8'hFF);
    end

    // Single digit: boundary every tick, frame_start every 2 cycles
    rst1_n          = 1'b1;
    bus1.digits_in  = 4'h5;
    bus1.dp_in      = 1'b1;
    bus1.blank_in   = 1'b0;
    bus1.load       = 1'b1;
    @(negedge clk);
    bus1.load       = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 1) chk1("n1_scan_lit", 1'b0, 8'h48, 1'b1);
      else            chk1("n1_scan_dead", 1'b1, 8'hFF, 1'b0);
    end
    @(negedge clk);
    chk1("n1_pre_reset", 1'b1, 8'hFF, 1'b0);
    rst1_n = 1'b0;
    @(negedge clk);
    chk1("n1_reset_abort", 1'b1, 8'hFF, 1'b0);
    rst1_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("n1_post_reset_dark", 1'b1, 8'hFF, (i % 2 == 1) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
